// File: rtl/alu_issue_stage.sv
// ALU issue stage: registers one operation for an external combinational ALU,
// captures the ALU result into a small result FIFO, and presents the FIFO head
// to a ready/valid consumer. Stage 0 is the operand register, stage 1 the FIFO.
module alu_issue_stage #(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_x,
  input  logic signed [N-1:0] in_y,
  input  logic [2:0]          in_sel,
  output logic signed [N-1:0] alu_x,
  output logic signed [N-1:0] alu_y,
  output logic [2:0]          alu_sel,
  input  logic signed [N+1:0] alu_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N+1:0] out_res,
  output logic [2:0]          out_sel,
  output logic [7:0]          op_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic                vld_p0;
  logic signed [N+1:0] res_mem_p1 [DEPTH];
  logic [2:0]          sel_mem_p1 [DEPTH];
  logic [PW-1:0]       rd_ptr_p1;
  logic [PW-1:0]       wr_ptr_p1;
  logic [CW-1:0]       count_p1;
  logic [PW-1:0]       rd_ptr_nxt;
  logic                can_push;
  logic                push;
  logic                pop;
  logic                accept;

  // Pointers wrap modulo DEPTH, so non-power-of-two depths work as well.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push
  // while the consumer is draining it; this keeps one op per cycle.
  assign out_valid  = (count_p1 != '0);
  assign pop        = out_valid & out_ready;
  assign can_push   = (count_p1 < FULL_CNT) | pop;
  assign push       = vld_p0 & can_push;
  assign in_ready   = ~vld_p0 | can_push;
  assign accept     = in_valid & in_ready;
  assign rd_ptr_nxt = ptr_inc(rd_ptr_p1);

  // ---- stage 0: operand register feeding the external ALU ----
  // Operands load on acceptance and stay put until the result is captured;
  // a push with a simultaneous accept keeps the register occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      alu_x   <= '0;
      alu_y   <= '0;
      alu_sel <= '0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      alu_x   <= in_x;
      alu_y   <= in_y;
      alu_sel <= in_sel;
    end else if (push) begin
      vld_p0  <= 1'b0;
    end
  end

  // ---- stage 1: result FIFO ----
  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem_p1[wr_ptr_p1] <= alu_out;
      sel_mem_p1[wr_ptr_p1] <= alu_sel;
    end
  end

  // FIFO pointers, occupancy and delivered-result counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_p1 <= '0;
      wr_ptr_p1 <= '0;
      count_p1  <= '0;
      op_count  <= '0;
    end else begin
      if (push) begin
        wr_ptr_p1 <= ptr_inc(wr_ptr_p1);
      end
      if (pop) begin
        rd_ptr_p1 <= rd_ptr_nxt;
        op_count  <= op_count + 8'd1;
      end
      case ({push, pop})
        2'b10:   count_p1 <= count_p1 + ONE_CNT;
        2'b01:   count_p1 <= count_p1 - ONE_CNT;
        default: count_p1 <= count_p1;
      endcase
    end
  end

  // Registered copy of the head so the outputs hold their last value once the
  // FIFO drains instead of showing whatever the next slot happens to contain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_res <= '0;
      out_sel <= '0;
    end else if (push && ((count_p1 == '0) || (pop && (count_p1 == ONE_CNT)))) begin
      out_res <= alu_out;
      out_sel <= alu_sel;
    end else if (pop && (count_p1 > ONE_CNT)) begin
      out_res <= res_mem_p1[rd_ptr_nxt];
      out_sel <= sel_mem_p1[rd_ptr_nxt];
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU on the alu_* ports, plus an
// occupancy/queue reference model of the issue stage advanced once per cycle.
module tb_alu_issue_stage;

  localparam int N     = 4;
  localparam int DEPTH = 2;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_x;
  logic signed [N-1:0] in_y;
  logic [2:0]          in_sel;
  logic signed [N-1:0] alu_x;
  logic signed [N-1:0] alu_y;
  logic [2:0]          alu_sel;
  logic signed [N+1:0] alu_out;
  logic                out_valid;
  logic                out_ready;
  logic signed [N+1:0] out_res;
  logic [2:0]          out_sel;
  logic [7:0]          op_count;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_sel    (in_sel),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_sel   (out_sel),
    .op_count  (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: operands sign-extended to N+2 bits.
  function automatic logic signed [N+1:0] alu_ref(input logic signed [N-1:0] x,
                                                  input logic signed [N-1:0] y,
                                                  input logic [2:0] s);
    logic signed [N+1:0] a;
    logic signed [N+1:0] b;
    a = (N+2)'(x);
    b = (N+2)'(y);
    case (s)
      3'd0:    return (a + b) >>> 1;
      3'd1:    return (a + b) <<< 1;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a & b;
      3'd5:    return ~a;
      3'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_out = alu_ref(alu_x, alu_y, alu_sel);

  typedef struct packed {
    logic signed [N+1:0] res;
    logic [2:0]          sel;
  } entry_t;

  // Reference model state
  entry_t              m_fifo[$];
  entry_t              m_op;
  entry_t              m_shown;
  logic                m_op_has;
  logic signed [N-1:0] m_ax;
  logic signed [N-1:0] m_ay;
  logic [2:0]          m_as;
  logic [7:0]          m_cnt;

  // Observed / expected values of the most recent sample
  logic                obs_ready, obs_valid, exp_ready, exp_valid;
  logic signed [N+1:0] obs_res, exp_res;
  logic [2:0]          obs_sel, exp_sel;
  logic [7:0]          obs_cnt, exp_cnt;
  logic [2*N+2:0]      obs_alu, exp_alu;

  task automatic model_clear();
    m_fifo.delete();
    m_op     = '0;
    m_shown  = '0;
    m_op_has = 1'b0;
    m_ax     = '0;
    m_ay     = '0;
    m_as     = '0;
    m_cnt    = '0;
  endtask

  // One clock cycle: drive inputs, sample DUT and model at the falling edge,
  // then advance the model across the rising edge.
  task automatic tick(input logic v, input logic signed [N-1:0] x,
                      input logic signed [N-1:0] y, input logic [2:0] s,
                      input logic ordy);
    logic   m_pop;
    logic   m_push;
    logic   m_acc;
    entry_t nxt;
    in_valid  = v;
    in_x      = x;
    in_y      = y;
    in_sel    = s;
    out_ready = ordy;
    @(negedge clk);
    obs_ready = in_ready;
    obs_valid = out_valid;
    obs_res   = out_res;
    obs_sel   = out_sel;
    obs_cnt   = op_count;
    obs_alu   = {alu_x, alu_y, alu_sel};
    exp_valid = (m_fifo.size() != 0);
    exp_ready = !m_op_has || (m_fifo.size() < DEPTH) || (exp_valid && ordy);
    exp_res   = m_shown.res;
    exp_sel   = m_shown.sel;
    exp_cnt   = m_cnt;
    exp_alu   = {m_ax, m_ay, m_as};
    m_pop     = exp_valid && ordy;
    m_push    = m_op_has && ((m_fifo.size() < DEPTH) || m_pop);
    m_acc     = v && exp_ready;
    nxt.res   = alu_ref(x, y, s);
    nxt.sel   = s;
    @(posedge clk);
    #1;
    if (m_pop) begin
      void'(m_fifo.pop_front());
      m_cnt = m_cnt + 8'd1;
    end
    if (m_push) m_fifo.push_back(m_op);
    if (m_acc) begin
      m_op_has = 1'b1;
      m_op     = nxt;
      m_ax     = x;
      m_ay     = y;
      m_as     = s;
    end else if (m_push) begin
      m_op_has = 1'b0;
    end
    if (m_fifo.size() != 0) m_shown = m_fifo[0];
  endtask

  // Short reset pulse placed between clock edges (no checks here).
  task automatic pulse_reset();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_res !== '0) begin errors++; $display("FAIL reset_out_res got %0d want 0", out_res); end
    checks++; if (out_sel !== 3'd0) begin errors++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
    checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    checks++; if ({alu_x, alu_y, alu_sel} !== '0) begin errors++; $display("FAIL reset_alu_regs got %h want 0", {alu_x, alu_y, alu_sel}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    tick(1'b0, '0, '0, 3'd0, 1'b0);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", obs_ready); end
  endtask

  task automatic test_single();
    pulse_reset();
    tick(1'b1, 4'sd6, 4'sd3, 3'd0, 1'b1);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", obs_ready); end
    tick(1'b0, '0, '0, 3'd0, 1'b1);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", obs_valid); end
    tick(1'b0, '0, '0, 3'd0, 1'b1);
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", obs_valid); end
    checks++; if (obs_res !== 6'b000100) begin errors++; $display("FAIL single_res got %0d want 4", obs_res); end
    checks++; if (obs_sel !== 3'd0) begin errors++; $display("FAIL single_sel got %0d want 0", obs_sel); end
    tick(1'b0, '0, '0, 3'd0, 1'b1);
    checks++; if (obs_cnt !== 8'd1) begin errors++; $display("FAIL single_op_count got %0d want 1", obs_cnt); end
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", obs_valid); end
    checks++; if (obs_res !== 6'b000100) begin errors++; $display("FAIL single_res_hold got %0d want 4", obs_res); end
  endtask

  task automatic test_extreme();
    tick(1'b1, 4'b1000, 4'b1000, 3'd1, 1'b1);
    tick(1'b1, 4'sd5, 4'sd0, 3'd5, 1'b1);
    tick(1'b0, '0, '0, 3'd0, 1'b1);
    checks++; if (obs_valid !== 1'b1 || obs_res !== 6'b100000 || obs_sel !== 3'd1) begin
      errors++; $display("FAIL extreme_min got v=%b res=%0d sel=%0d want v=1 res=-32 sel=1", obs_valid, obs_res, obs_sel);
    end
    tick(1'b0, '0, '0, 3'd0, 1'b1);
    checks++; if (obs_valid !== 1'b1 || obs_res !== 6'b111010 || obs_sel !== 3'd5) begin
      errors++; $display("FAIL extreme_not got v=%b res=%0d sel=%0d want v=1 res=-6 sel=5", obs_valid, obs_res, obs_sel);
    end
    tick(1'b0, '0, '0, 3'd0, 1'b1);
    checks++; if (obs_valid !== 1'b0 || obs_res !== 6'b111010) begin
      errors++; $display("FAIL extreme_hold got v=%b res=%0d want v=0 res=-6", obs_valid, obs_res);
    end
  endtask

  task automatic test_backpressure();
    logic signed [N-1:0] bx [4];
    logic signed [N-1:0] by [4];
    logic [2:0]          bs [4];
    entry_t              want [4];
    entry_t              got[$];
    int                  k;
    logic                v;
    logic                o;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      bx[i] = N'($urandom);
      by[i] = N'($urandom);
      bs[i] = 3'($urandom);
      want[i].res = alu_ref(bx[i], by[i], bs[i]);
      want[i].sel = bs[i];
    end
    for (int t = 0; t < 10; t++) begin
      k = (t < 4) ? t : 3;
      v = (t < 5);
      o = (t >= 4);
      tick(v, bx[k], by[k], bs[k], o);
      if (obs_valid && o) got.push_back({obs_res, obs_sel});
      if (t < 5) begin
        checks++; if (obs_ready !== (t != 3)) begin errors++; $display("FAIL bp_in_ready t=%0d got %b want %b", t, obs_ready, (t != 3)); end
      end
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL bp_out_valid t=%0d got %b want %b", t, obs_valid, exp_valid); end
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_result_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== want[i]) begin
        errors++; $display("FAIL bp_order idx=%0d got res=%0d sel=%0d want res=%0d sel=%0d", i, got[i].res, got[i].sel, want[i].res, want[i].sel);
      end
    end
  endtask

  task automatic test_streaming();
    logic signed [N-1:0] xs [8];
    logic signed [N-1:0] ys [8];
    logic                ev;
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      xs[i] = N'($urandom);
      ys[i] = N'($urandom);
    end
    for (int i = 0; i < 12; i++) begin
      if (i < 8) tick(1'b1, xs[i], ys[i], 3'(i), 1'b1);
      else       tick(1'b0, '0, '0, 3'd0, 1'b1);
      ev = (i >= 2 && i <= 9);
      if (i < 8) begin
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready i=%0d got %b want 1", i, obs_ready); end
      end
      checks++; if (obs_valid !== ev) begin errors++; $display("FAIL stream_out_valid i=%0d got %b want %b", i, obs_valid, ev); end
      if (ev) begin
        checks++; if (obs_res !== alu_ref(xs[i-2], ys[i-2], 3'(i-2)) || obs_sel !== 3'(i-2)) begin
          errors++; $display("FAIL stream_result i=%0d got res=%0d sel=%0d want res=%0d sel=%0d", i, obs_res, obs_sel, alu_ref(xs[i-2], ys[i-2], 3'(i-2)), 3'(i-2));
        end
      end
    end
  endtask

  task automatic test_random();
    logic          v;
    logic          o;
    logic [N-1:0]  x;
    logic [N-1:0]  y;
    logic [2:0]    s;
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      v = 1'($urandom_range(1));
      o = ($urandom_range(3) != 0);
      x = N'($urandom);
      y = N'($urandom);
      s = 3'($urandom);
      tick(v, x, y, s, o);
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_in_ready i=%0d got %b want %b", i, obs_ready, exp_ready); end
      checks++; if (obs_valid !== exp_valid) begin errors++; $display("FAIL rand_out_valid i=%0d got %b want %b", i, obs_valid, exp_valid); end
      checks++; if (obs_res !== exp_res || obs_sel !== exp_sel) begin
        errors++; $display("FAIL rand_head i=%0d got res=%0d sel=%0d want res=%0d sel=%0d", i, obs_res, obs_sel, exp_res, exp_sel);
      end
      checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL rand_op_count i=%0d got %0d want %0d", i, obs_cnt, exp_cnt); end
      checks++; if (obs_alu !== exp_alu) begin errors++; $display("FAIL rand_alu_regs i=%0d got %h want %h", i, obs_alu, exp_alu); end
    end
  endtask

  task automatic test_reset_midflight();
    pulse_reset();
    tick(1'b1, 4'sd1, 4'sd2, 3'd2, 1'b0);
    tick(1'b1, 4'sd3, 4'sd4, 3'd3, 1'b0);
    tick(1'b1, 4'sd5, 4'sd6, 3'd6, 1'b0);
    tick(1'b0, '0, '0, 3'd0, 1'b0);
    checks++; if (obs_ready !== 1'b0 || obs_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full got ready=%b valid=%b want ready=0 valid=1", obs_ready, obs_valid);
    end
    #1 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_res !== '0 || out_sel !== 3'd0 || op_count !== 8'd0) begin
      errors++; $display("FAIL mid_reset_outputs got v=%b res=%0d sel=%0d cnt=%0d want all 0", out_valid, out_res, out_sel, op_count);
    end
    checks++; if ({alu_x, alu_y, alu_sel} !== '0) begin errors++; $display("FAIL mid_reset_alu got %h want 0", {alu_x, alu_y, alu_sel}); end
    #1 reset = 1'b0;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, '0, '0, 3'd0, 1'b1);
      if (i == 0) begin
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", obs_ready); end
      end
      checks++; if (obs_valid !== 1'b0 || obs_res !== '0) begin
        errors++; $display("FAIL mid_stale i=%0d got v=%b res=%0d want v=0 res=0", i, obs_valid, obs_res);
      end
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int i = 0; i < 262; i++) begin
      tick((i < 257), N'($urandom), N'($urandom), 3'($urandom), 1'b1);
      checks++; if (obs_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_op_count i=%0d got %0d want %0d", i, obs_cnt, exp_cnt); end
    end
    checks++; if (obs_cnt !== 8'd1) begin errors++; $display("FAIL wrap_final got %0d want 1", obs_cnt); end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_sel    = '0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_single();
    test_extreme();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_midflight();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
